// File: rtl/apb_mem_slave_if.sv
// apb_mem_slave_if: APB select/access bundle between a master and apb_mem_slave.
interface apb_mem_slave_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned WAIT_W = 8
);
  logic [SEL_W-1:0]  sel;
  logic              enable;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [WAIT_W-1:0] wait_cycles;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              slverr;

  modport master (
    output sel, enable, write, addr, wdata, wait_cycles,
    input  ready, rdata, slverr
  );

  modport slave (
    input  sel, enable, write, addr, wdata, wait_cycles,
    output ready, rdata, slverr
  );
endinterface

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB slave backed by a word-addressed register array with programmable wait states.
// Optional feature macro APB_SLVERR_EN: when defined, out-of-range accesses raise slverr.
module apb_mem_slave #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned SLAVE_ID = 0,
  parameter int unsigned WAIT_W   = 8
) (
  input logic            clk,
  input logic            reset,
  apb_mem_slave_if.slave bus
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CMP_W = (ADDR_W > 32) ? ADDR_W + 1 : 33;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_q;
  logic              err_q;
  logic [WAIT_W-1:0] cnt_q;

  logic             sel_c;
  logic             in_range_c;
  logic [IDX_W-1:0] idx_c;
  logic             ready_c;
  logic             unused_sel_c;

  // Full-width compare so high addresses never alias into the array.
  assign sel_c        = bus.sel[SLAVE_ID];
  assign in_range_c   = CMP_W'(bus.addr) < CMP_W'(DEPTH);
  assign idx_c        = bus.addr[IDX_W-1:0];
  assign unused_sel_c = ^bus.sel;

  assign ready_c   = (state == ACCESS) && (cnt_q == '0) && bus.enable && sel_c;
  assign bus.ready = ready_c;
  assign bus.rdata = (ready_c && !write_q) ? rd_q : '0;
`ifdef APB_SLVERR_EN
  assign bus.slverr = ready_c && err_q;
`else
  assign bus.slverr = 1'b0;
`endif

  // Transfer sequencing, wait-state counting and array update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[IDX_W'(i)] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (sel_c && !bus.enable) begin
            idx_q   <= idx_c;
            write_q <= bus.write;
            wdata_q <= bus.wdata;
            cnt_q   <= bus.wait_cycles;
            rd_q    <= in_range_c ? mem[idx_c] : '0;
            err_q   <= !in_range_c;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!sel_c) begin
            state <= IDLE;
          end else if (bus.enable) begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - WAIT_W'(1);
            end else begin
              if (write_q && !err_q) begin
                mem[idx_q] <= wdata_q;
              end
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: randomized APB traffic against an array model, checked by a scoreboard monitor.
module tb_apb_mem_slave;
  localparam int unsigned DEPTH = 16;
`ifdef APB_SLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] rdata;
    logic       slverr;
    int         cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   acc;
  exp_t q[$];
  exp_t e_mon;
  logic [7:0] model [DEPTH];

  apb_mem_slave_if #(.DATA_W(8), .ADDR_W(8), .SEL_W(2), .WAIT_W(8)) bus ();

  apb_mem_slave #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .SEL_W(2), .SLAVE_ID(0), .WAIT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: pops an expectation on every ready pulse, otherwise requires quiet outputs.
  always @(negedge clk) begin
    if (reset) begin
      acc = 0;
    end else begin
      if (bus.sel[0] && bus.enable) acc++;
      if (bus.ready === 1'b1) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_ready: got ready=1 expected no pending transfer");
        end else begin
          e_mon = q.pop_front();
          chk("rdata", 32'(bus.rdata), 32'(e_mon.rdata));
          chk("slverr", 32'(bus.slverr), 32'(e_mon.slverr));
          chk("ready_cycle", 32'(acc), 32'(e_mon.cyc));
        end
        acc = 0;
      end else begin
        chk("ready_low", 32'(bus.ready), 32'h0);
        chk("idle_rdata", 32'(bus.rdata), 32'h0);
        chk("idle_slverr", 32'(bus.slverr), 32'h0);
      end
      if (!bus.sel[0]) acc = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input bit wr, input int a, input logic [7:0] d, input int w);
    bus.sel         = 2'b01;
    bus.enable      = 1'b0;
    bus.write       = wr;
    bus.addr        = 8'(a);
    bus.wdata       = d;
    bus.wait_cycles = 8'(w);
  endtask

  task automatic xfer(input bit wr, input int a, input logic [7:0] d, input int w, input bit stalls);
    exp_t e;
    bit   inr;
    bit   done;
    int   budget;
    inr      = (a < int'(DEPTH));
    e.rdata  = (!wr && inr) ? model[a] : 8'h00;
    e.slverr = ERR_EN && !inr;
    e.cyc    = w + 1;
    q.push_back(e);
    setup(wr, a, d, w);
    tick();
    bus.enable      = 1'b1;
    bus.addr        = 8'($urandom);
    bus.wdata       = 8'($urandom);
    bus.wait_cycles = 8'($urandom);
    bus.write       = 1'($urandom);
    done   = 1'b0;
    budget = 0;
    while (!done) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        done = 1'b1;
      end else begin
        budget++;
        if (budget > 4 * w + 20) begin
          total++;
          bad++;
          $display("FAIL ready_timeout: got no ready expected ready within %0d cycles", budget);
          done = 1'b1;
          void'(q.pop_back());
        end else begin
          tick();
          bus.enable = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end
    end
    if (wr && inr) model[a] = d;
    tick();
    bus.sel    = 2'b00;
    bus.enable = 1'b0;
  endtask

  task automatic abort_xfer(input int a, input logic [7:0] d, input int w, input int k);
    setup(1'b1, a, d, w);
    tick();
    bus.enable = 1'b1;
    repeat (k) tick();
    bus.sel    = 2'b00;
    bus.enable = 1'b0;
    tick();
  endtask

  task automatic reset_mid(input int a, input logic [7:0] d);
    setup(1'b1, a, d, 4);
    tick();
    bus.enable = 1'b1;
    tick();
    reset      = 1'b1;
    bus.sel    = 2'b00;
    bus.enable = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 8'h00;
  endtask

  task automatic other_slave(input int n);
    bus.sel   = 2'b10;
    bus.write = 1'b1;
    bus.addr  = 8'($urandom_range(0, DEPTH - 1));
    bus.wdata = 8'($urandom);
    bus.wait_cycles = 8'h00;
    for (int i = 0; i < n; i++) begin
      bus.enable = i[0];
      tick();
    end
    bus.sel    = 2'b00;
    bus.enable = 1'b0;
  endtask

  task automatic violation();
    bus.sel    = 2'b01;
    bus.enable = 1'b1;
    bus.write  = 1'b1;
    bus.addr   = 8'($urandom_range(0, DEPTH - 1));
    bus.wdata  = 8'($urandom);
    bus.wait_cycles = 8'h00;
    tick();
    bus.sel    = 2'b00;
    bus.enable = 1'b0;
    tick();
  endtask

  initial begin
    int op;
    int a;
    total = 0;
    bad   = 0;
    acc   = 0;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 8'h00;
    reset = 1'b1;
    bus.sel = 2'b00;
    bus.enable = 1'b0;
    bus.write = 1'b0;
    bus.addr = 8'h00;
    bus.wdata = 8'h00;
    bus.wait_cycles = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    xfer(1'b0, 3, 8'h00, 0, 1'b0);
    xfer(1'b1, 5, 8'hA5, 0, 1'b0);
    xfer(1'b0, 5, 8'h00, 3, 1'b0);
    xfer(1'b1, 4, 8'h5A, 0, 1'b0);
    xfer(1'b1, 20, 8'h3C, 0, 1'b0);
    xfer(1'b0, 4, 8'h00, 0, 1'b0);
    xfer(1'b0, 200, 8'h00, 1, 1'b0);
    xfer(1'b1, 2, 8'h22, 0, 1'b0);
    abort_xfer(2, 8'h77, 5, 1);
    xfer(1'b0, 2, 8'h00, 0, 1'b0);
    xfer(1'b1, 1, 8'h99, 0, 1'b0);
    reset_mid(1, 8'h11);
    xfer(1'b0, 1, 8'h00, 0, 1'b0);
    xfer(1'b1, 7, 8'hC3, 1, 1'b0);
    other_slave(6);
    xfer(1'b0, 7, 8'h00, 0, 1'b0);
    violation();
    xfer(1'b0, 15, 8'h00, 255, 1'b0);

    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 11);
      a  = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 255) : $urandom_range(0, DEPTH - 1);
      case (op)
        0: abort_xfer(a, 8'($urandom), $urandom_range(1, 6), 1);
        1: other_slave($urandom_range(2, 5));
        2: violation();
        default: begin
          xfer(1'($urandom), a, 8'($urandom), $urandom_range(0, 6), 1'($urandom));
          if ($urandom_range(0, 2) == 0) tick();
        end
      endcase
    end

    repeat (4) tick();
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
